// File: rtl/trap_controller_pkg.sv
// Shared definitions for the trap controller: cause codes, access-size
// encodings, sequencer states and the memory-access alignment helper.
package trap_controller_pkg;

    localparam logic [4:0] CAUSE_INST_MISALIGNED  = 5'd0;
    localparam logic [4:0] CAUSE_ILLEGAL_INST     = 5'd2;
    localparam logic [4:0] CAUSE_BREAKPOINT       = 5'd3;
    localparam logic [4:0] CAUSE_LOAD_MISALIGNED  = 5'd4;
    localparam logic [4:0] CAUSE_STORE_MISALIGNED = 5'd6;
    localparam logic [4:0] CAUSE_ECALL_U          = 5'd8;
    localparam logic [4:0] CAUSE_ECALL_M          = 5'd11;

    localparam logic [4:0] IRQ_CODE_MSI = 5'd3;
    localparam logic [4:0] IRQ_CODE_MTI = 5'd7;
    localparam logic [4:0] IRQ_CODE_MEI = 5'd11;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CSR_WR,
        ST_MRET_WR,
        ST_REDIRECT
    } state_t;

    // An access size the datapath cannot perform is reported as misaligned.
    function automatic logic access_misaligned(input logic [2:0] low_addr,
                                               input logic [2:0] funct3,
                                               input logic       wide);
        logic legal;
        logic bad;
        legal = (funct3 != 3'b111) && (wide || (funct3 != 3'b011 && funct3 != 3'b110));
        case (funct3[1:0])
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = low_addr[0];
            SIZE_W:  bad = |low_addr[1:0];
            default: bad = |low_addr;
        endcase
        return !legal || bad;
    endfunction

endpackage

// File: rtl/trap_controller_if.sv
// CSR-update and PC-redirect handshakes between the trap controller (master)
// and the CSR file / fetch unit (slave).
interface trap_controller_if #(
    parameter int XLEN = 32
);
    logic            csr_trap_req;
    logic            csr_mret_req;
    logic            csr_ack;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_epc;
    logic [XLEN-1:0] trap_tval;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;

    modport master (
        output csr_trap_req, csr_mret_req, trap_cause, trap_epc, trap_tval,
               redirect_valid, redirect_pc,
        input  csr_ack, redirect_ready
    );

    modport slave (
        input  csr_trap_req, csr_mret_req, trap_cause, trap_epc, trap_tval,
               redirect_valid, redirect_pc,
        output csr_ack, redirect_ready
    );
endinterface

// File: rtl/trap_controller_detect.sv
// Combinational exception/interrupt detection with fixed priority
// IF > ID (EBREAK, ECALL, illegal) > MEM > interrupts; also flags MRET.
module trap_detect
    import trap_controller_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int IALIGN    = 32,
    parameter int PRIV_U_EN = 0
) (
    input  logic [XLEN-1:0] if_pc,
    input  logic            if_valid,
    input  logic            id_illegal_inst,
    input  logic            id_ecall,
    input  logic            id_ebreak,
    input  logic            id_mret,
    input  logic [XLEN-1:0] id_pc,
    input  logic [31:0]     id_instruction,
    input  logic            id_valid,
    input  logic [XLEN-1:0] mem_addr,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      mem_funct3,
    input  logic [XLEN-1:0] mem_pc,
    input  logic            mem_valid,
    input  logic [1:0]      cur_priv,
    input  logic            mstatus_mie,
    input  logic [2:0]      irq_pending,
    output logic            trap_valid,
    output logic [XLEN-1:0] trap_cause,
    output logic [XLEN-1:0] trap_epc,
    output logic [XLEN-1:0] trap_tval,
    output logic            mret_valid
);

    localparam logic WIDE = (XLEN == 64);

    logic       if_misaligned;
    logic       mem_misaligned;
    logic       is_irq;
    logic [4:0] code;

    always_comb begin
        if_misaligned  = if_valid && ((IALIGN == 16) ? if_pc[0] : (if_pc[1:0] != 2'b00));
        mem_misaligned = mem_valid && (mem_read || mem_write) &&
                         access_misaligned(mem_addr[2:0], mem_funct3, WIDE);
    end

    always_comb begin
        trap_valid = 1'b0;
        is_irq     = 1'b0;
        code       = 5'd0;
        trap_epc   = '0;
        trap_tval  = '0;
        if (if_misaligned) begin
            trap_valid = 1'b1;
            code       = CAUSE_INST_MISALIGNED;
            trap_epc   = if_pc;
            trap_tval  = if_pc;
        end else if (id_valid && id_ebreak) begin
            trap_valid = 1'b1;
            code       = CAUSE_BREAKPOINT;
            trap_epc   = id_pc;
            trap_tval  = id_pc;
        end else if (id_valid && id_ecall) begin
            trap_valid = 1'b1;
            code       = (PRIV_U_EN != 0 && cur_priv == 2'b00) ? CAUSE_ECALL_U : CAUSE_ECALL_M;
            trap_epc   = id_pc;
        end else if (id_valid && id_illegal_inst) begin
            trap_valid = 1'b1;
            code       = CAUSE_ILLEGAL_INST;
            trap_epc   = id_pc;
            trap_tval  = XLEN'(id_instruction);
        end else if (mem_misaligned) begin
            trap_valid = 1'b1;
            code       = mem_read ? CAUSE_LOAD_MISALIGNED : CAUSE_STORE_MISALIGNED;
            trap_epc   = mem_pc;
            trap_tval  = mem_addr;
        end else if (mstatus_mie && id_valid && (irq_pending != 3'b000)) begin
            // Interrupts are taken on the instruction sitting in ID
            trap_valid = 1'b1;
            is_irq     = 1'b1;
            code       = irq_pending[2] ? IRQ_CODE_MEI :
                         irq_pending[0] ? IRQ_CODE_MSI : IRQ_CODE_MTI;
            trap_epc   = id_pc;
        end
    end

    always_comb begin
        trap_cause         = '0;
        trap_cause[4:0]    = code;
        trap_cause[XLEN-1] = is_irq;
        mret_valid         = id_valid && id_mret && !trap_valid;
    end

endmodule

// File: rtl/trap_controller.sv
// Trap entry / MRET sequencer: flush, CSR write handshake, PC redirect.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt targets.
module trap_controller
    import trap_controller_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int IALIGN    = 32,
    parameter int PRIV_U_EN = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [XLEN-1:0]        if_pc,
    input  logic                   if_valid,
    input  logic                   id_illegal_inst,
    input  logic                   id_ecall,
    input  logic                   id_ebreak,
    input  logic                   id_mret,
    input  logic [XLEN-1:0]        id_pc,
    input  logic [31:0]            id_instruction,
    input  logic                   id_valid,
    input  logic [XLEN-1:0]        mem_addr,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [2:0]             mem_funct3,
    input  logic [XLEN-1:0]        mem_pc,
    input  logic                   mem_valid,
    input  logic [1:0]             cur_priv,
    input  logic                   mstatus_mie,
    input  logic [2:0]             irq_pending,
    input  logic [XLEN-1:0]        mtvec,
    input  logic [XLEN-1:0]        mepc,
    output logic                   flush,
    output logic                   busy,
    trap_controller_if.master      bus
);

    state_t          state_q, state_d;
    logic [XLEN-1:0] cause_q, epc_q, tval_q, redirect_pc_q;
    logic            det_valid, mret_valid;
    logic [XLEN-1:0] det_cause, det_epc, det_tval;
    logic            capture, load_target;
    logic [XLEN-1:0] target_d, trap_base, trap_target;
    logic            trap_req, mret_req, redirect_valid;

    trap_detect #(
        .XLEN      (XLEN),
        .IALIGN    (IALIGN),
        .PRIV_U_EN (PRIV_U_EN)
    ) u_detect (
        .if_pc           (if_pc),
        .if_valid        (if_valid),
        .id_illegal_inst (id_illegal_inst),
        .id_ecall        (id_ecall),
        .id_ebreak       (id_ebreak),
        .id_mret         (id_mret),
        .id_pc           (id_pc),
        .id_instruction  (id_instruction),
        .id_valid        (id_valid),
        .mem_addr        (mem_addr),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_funct3      (mem_funct3),
        .mem_pc          (mem_pc),
        .mem_valid       (mem_valid),
        .cur_priv        (cur_priv),
        .mstatus_mie     (mstatus_mie),
        .irq_pending     (irq_pending),
        .trap_valid      (det_valid),
        .trap_cause      (det_cause),
        .trap_epc        (det_epc),
        .trap_tval       (det_tval),
        .mret_valid      (mret_valid)
    );

    always_comb begin
        trap_base = mtvec & ~XLEN'(3);
`ifdef TRAP_VECTORED_EN
        if (mtvec[1:0] == 2'b01 && cause_q[XLEN-1])
            trap_target = trap_base + (XLEN'(cause_q[4:0]) << 2);
        else
            trap_target = trap_base;
`else
        trap_target = trap_base;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cause_q       <= '0;
            epc_q         <= '0;
            tval_q        <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                cause_q <= det_cause;
                epc_q   <= det_epc;
                tval_q  <= det_tval;
            end
            if (load_target)
                redirect_pc_q <= target_d;
        end
    end

    // Flush is Mealy so the younger instructions die in the detect cycle itself
    always_comb begin
        state_d        = state_q;
        flush          = 1'b0;
        capture        = 1'b0;
        load_target    = 1'b0;
        target_d       = trap_target;
        trap_req       = 1'b0;
        mret_req       = 1'b0;
        redirect_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (det_valid) begin
                    flush   = 1'b1;
                    capture = 1'b1;
                    state_d = ST_CSR_WR;
                end else if (mret_valid) begin
                    flush   = 1'b1;
                    state_d = ST_MRET_WR;
                end
            end
            ST_CSR_WR: begin
                trap_req = 1'b1;
                if (bus.csr_ack) begin
                    load_target = 1'b1;
                    state_d     = ST_REDIRECT;
                end
            end
            ST_MRET_WR: begin
                mret_req = 1'b1;
                if (bus.csr_ack) begin
                    load_target = 1'b1;
                    target_d    = mepc;
                    state_d     = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                if (bus.redirect_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy               = (state_q != ST_IDLE);
    assign bus.csr_trap_req   = trap_req;
    assign bus.csr_mret_req   = mret_req;
    assign bus.trap_cause     = cause_q;
    assign bus.trap_epc       = epc_q;
    assign bus.trap_tval      = tval_q;
    assign bus.redirect_valid = redirect_valid;
    assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Parametrised successor to the combinational exception detector.
- Detects synchronous exceptions from the IF, ID and MEM stages, plus machine interrupts.
- Arbitrates them by fixed priority and sequences trap entry over several cycles: pipeline flush, CSR trap write handshake, PC redirect handshake.
- Also sequences MRET return.
- Sits beside the CSR file in the core; drives the flush and redirect logic of the hazard unit.

Parameters:
- XLEN, 32, datapath width (32 or 64); selects which funct3 loads/stores are legal and sets the mcause interrupt bit position.
- IALIGN, 32, instruction alignment in bits (32 or 16); 16 means compressed enabled, so only pc[0] is checked.
- PRIV_U_EN, 0, 1 enables U-mode ECALL cause 8; 0 means all ECALLs report cause 11.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous active-high reset
- if_pc  in  XLEN  fetch PC
- if_valid  in  1  IF stage holds a live instruction
- id_illegal_inst  in  1  decoder illegal flag
- id_ecall  in  1  ECALL decoded
- id_ebreak  in  1  EBREAK decoded
- id_mret  in  1  MRET decoded
- id_pc  in  XLEN  ID PC
- id_instruction  in  32  ID instruction word
- id_valid  in  1  ID stage holds a live instruction
- mem_addr  in  XLEN  effective address
- mem_read  in  1  load in MEM
- mem_write  in  1  store in MEM
- mem_funct3  in  3  access size
- mem_pc  in  XLEN  MEM PC
- mem_valid  in  1  MEM stage holds a live instruction
- cur_priv  in  2  current privilege (3=M, 0=U)
- mstatus_mie  in  1  global interrupt enable
- irq_pending  in  3  {MEI,MTI,MSI} = mip & mie
- mtvec  in  XLEN  trap vector CSR
- mepc  in  XLEN  return address CSR
- flush  out  1  kill all younger-than-trap instructions
- busy  out  1  sequencer not IDLE; stalls the pipeline
- csr_trap_req  out  1  request CSR trap update
- csr_mret_req  out  1  request CSR MRET update
- csr_ack  in  1  CSR file done
- trap_cause  out  XLEN  mcause value
- trap_epc  out  XLEN  mepc value
- trap_tval  out  XLEN  mtval value
- redirect_valid  out  1  PC redirect offered
- redirect_pc  out  XLEN  redirect target
- redirect_ready  in  1  fetch accepted redirect

Behaviour:
- Reset: state=IDLE; all outputs 0. Reset mid-sequence returns to IDLE immediately; any pending request is dropped.
- Combinational detect, priority high to low:
  - IF misaligned: pc[1:0]!=0 when IALIGN=32, pc[0] when IALIGN=16.
  - ID: EBREAK(3), then ECALL (11, or 8 if PRIV_U_EN and cur_priv==0), then illegal(2), each qualified by id_valid.
  - MEM misaligned: load cause 4, store cause 6. H needs addr[0]==0; W needs addr[1:0]==0; D (funct3 011) needs addr[2:0]==0 when XLEN=64 and is illegal-size (treated as misaligned) when XLEN=32; B is never misaligned.
- tval by cause:
  - IF misaligned: bad PC.
  - Illegal: instruction word, zero-extended.
  - EBREAK: PC.
  - ECALL: 0.
  - MEM misaligned: address.
- Interrupts: considered only when no synchronous exception is detected and mstatus_mie=1. Priority MEI(11) > MSI(3) > MTI(7). The interrupt is attributed to id_pc and requires id_valid. Cause bit XLEN-1 is set; tval=0.
- FSM:
  - IDLE: on exception/interrupt, capture cause/epc/tval into registers, assert flush for exactly 1 cycle, go to CSR_WR. On id_mret (id_valid, no exception), flush 1 cycle, go to MRET_WR. An exception takes precedence over a simultaneous MRET.
  - CSR_WR: csr_trap_req held high with stable cause/epc/tval until csr_ack is sampled high; then compute target and go to REDIRECT.
  - MRET_WR: csr_mret_req held high until csr_ack; target=mepc, sampled on the ack cycle.
  - REDIRECT: redirect_valid=1 with stable redirect_pc until redirect_ready; then IDLE.
- Trap target: {mtvec[XLEN-1:2],2'b00}.
- busy=1 in every state except IDLE. New detections are ignored while busy.
- Minimum trap latency: 3 cycles (detect, ack, ready each in consecutive cycles).

Optional Feature:
- TRAP_VECTORED_EN defined: when mtvec[1:0]==01 and the trap is an interrupt, target = base + 4*cause_code. Exceptions always go to base.
- Undefined: mtvec[1:0] ignored; all traps go to base.

Decomposition:
- Shared package: cause-code constants (0,2,3,4,6,8,11 and interrupt codes 3,7,11), FSM state encoding, funct3 size constants.
- Natural sub-module: trap_detect, holding the combinational priority and cause/tval selection. The parent holds the FSM and capture registers.

Test Plan:
- if_pc=0x102, if_valid, IALIGN=32 -> flush 1 cycle; csr_trap_req with cause 0, epc 0x102, tval 0x102. Ack then ready -> redirect_pc=mtvec base.
- Same PC with IALIGN=16 -> no trap. Then if_pc=0x101 -> cause 0.
- id_ebreak+id_ecall both set, id_pc=0x500 -> cause 3, tval 0x500. csr_ack withheld 5 cycles -> req and outputs stable, busy=1.
- XLEN=64, funct3=011, mem_read, addr 0x1004 -> cause 4, tval 0x1004. Addr 0x1008 -> no trap.
- irq_pending=3'b101, mstatus_mie=1, mtvec=0x8000_0001, id_pc=0x200:
  - With TRAP_VECTORED_EN: cause 0x8000000B, redirect 0x8000_002C.
  - Without TRAP_VECTORED_EN: cause 0x8000000B, redirect 0x8000_0000.
- id_mret, mepc=0x340 -> csr_mret_req, then redirect 0x340. Assert reset during REDIRECT -> next cycle all outputs 0, IDLE.
